stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_pkg.sv | 21 ++
 rtl/stopwatch_ctrl_edge_pulse.sv | 23 ++
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared state encoding and BCD constants for the stopwatch controller
// Contents: sw_state_t (controller states), BCD_TERMINAL_DIGIT, is_counting()
package stopwatch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_LAP     = 3'd3,
    ST_DONE    = 3'd4
  } sw_state_t;

  // Highest value a BCD digit may hold; an up-count ends when every digit is here.
  localparam int unsigned BCD_TERMINAL_DIGIT = 9;

  // States in which the prescaler advances and ticks are issued.
  function automatic logic is_counting(input sw_state_t s);
    return (s == ST_RUNNING) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_edge_pulse.sv
// rtl/stopwatch_ctrl_edge_pulse.sv - rising-edge press detector for one debounced button
// Ports: clk, rst (sync, active-high), level (debounced button), pulse (one cycle on 0->1)
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // History resets to 1 so a button held through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q & ~rst;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM driving an external BCD counter and display
// Ports: clk, rst (sync, active-high); start_stop, lap, clear (debounced levels);
//        mode_down (1 = count down); count (current counter value);
//        count_enable (tick pulse), count_up_down (1 = up), count_clear (clear pulse);
//        display_number (value to show), running (RUNNING or LAP), done (DONE)
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int NUMBER_OF_DIGITS         = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT = 4,
  parameter int TICK_DIVIDER             = 1_000_000
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  start_stop,
  input  logic                                                  lap,
  input  logic                                                  clear,
  input  logic                                                  mode_down,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] count,
  output logic                                                  count_enable,
  output logic                                                  count_up_down,
  output logic                                                  count_clear,
  output logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] display_number,
  output logic                                                  running,
  output logic                                                  done
);

  localparam int W  = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
  localparam int NB = NUMBER_OF_BITS_PER_DIGIT;
  localparam int PW = $clog2(TICK_DIVIDER);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIVIDER - 1);
  localparam logic [NB-1:0] DIGIT_NINE = NB'(BCD_TERMINAL_DIGIT);

  logic start_pulse;
  logic lap_pulse;
  logic clear_pulse;

  edge_pulse u_start_edge (.clk(clk), .rst(rst), .level(start_stop), .pulse(start_pulse));
  edge_pulse u_lap_edge   (.clk(clk), .rst(rst), .level(lap),        .pulse(lap_pulse));
  edge_pulse u_clear_edge (.clk(clk), .rst(rst), .level(clear),      .pulse(clear_pulse));

  sw_state_t       state_q, next_state;
  logic [PW-1:0]   presc_q, presc_d;
  logic            count_enable_d;
  logic            up_q, up_d;
  logic            count_clear_d;
  logic [W-1:0]    display_d;
  logic            running_d;
  logic            done_d;

  logic            tick;
  logic            all_nines;
  logic            terminal;

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
      if (count[i*NB +: NB] != DIGIT_NINE) begin
        all_nines = 1'b0;
      end
    end
  end

  // A terminal tick replaces the counter step instead of letting the counter wrap.
  assign tick     = is_counting(state_q) && (presc_q == PRESC_LAST);
  assign terminal = tick && (up_q ? all_nines : (count == '0));

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      presc_q        <= '0;
      count_enable   <= 1'b0;
      up_q           <= 1'b1;
      count_clear    <= 1'b1;  // still high in the first cycle after reset releases
      display_number <= '0;
      running        <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= next_state;
      presc_q        <= presc_d;
      count_enable   <= count_enable_d;
      up_q           <= up_d;
      count_clear    <= count_clear_d;
      display_number <= display_d;
      running        <= running_d;
      done           <= done_d;
    end
  end

  assign count_up_down = up_q;

  // Next-state logic: clear beats everything, a finished count beats buttons,
  // start beats lap; lower-priority presses in the same cycle are dropped.
  always_comb begin
    next_state = state_q;
    if (clear_pulse) begin
      next_state = ST_IDLE;
    end else if (terminal) begin
      next_state = ST_DONE;
    end else if (start_pulse) begin
      case (state_q)
        ST_IDLE:    next_state = ST_RUNNING;
        ST_RUNNING: next_state = ST_PAUSED;
        ST_PAUSED:  next_state = ST_RUNNING;
        ST_LAP:     next_state = ST_PAUSED;
        default:    next_state = state_q;
      endcase
    end else if (lap_pulse) begin
      case (state_q)
        ST_RUNNING: next_state = ST_LAP;
        ST_LAP:     next_state = ST_RUNNING;
        default:    next_state = state_q;
      endcase
    end
  end

  // Output logic: values to be registered at the next edge.
  always_comb begin
    presc_d        = presc_q;
    count_enable_d = tick && !terminal && !clear_pulse;
    count_clear_d  = clear_pulse;
    up_d           = up_q;
    display_d      = count;
    running_d      = is_counting(next_state);
    done_d         = (next_state == ST_DONE);

    if (clear_pulse || (state_q == ST_IDLE) || (state_q == ST_DONE)) begin
      presc_d = '0;
    end else if (is_counting(state_q)) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end

    // Direction is only sampled when a run starts from IDLE.
    if ((state_q == ST_IDLE) && (next_state == ST_RUNNING)) begin
      up_d = ~mode_down;
    end

    // Entering LAP captures the current count; staying in LAP keeps it frozen.
    if ((next_state == ST_LAP) && (state_q == ST_LAP)) begin
      display_d = display_number;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with a behavioural reference model
module tb_stopwatch_ctrl;

  localparam int TICKS = 4;

  logic        clk;
  logic        rst;
  logic        start_stop;
  logic        lap;
  logic        clear;
  logic        mode_down;
  logic [15:0] count;
  logic        count_enable;
  logic        count_up_down;
  logic        count_clear;
  logic [15:0] display_number;
  logic        running;
  logic        done;

  int errors = 0;
  int checks = 0;

  // Reference model: stopwatch described by independent flags and a tick phase.
  bit          mdl_idle, mdl_run, mdl_frozen, mdl_finished, mdl_up;
  int          mdl_phase;
  logic [15:0] mdl_hold;
  bit          prev_ss, prev_lp, prev_cl;
  logic        exp_ce, exp_ud, exp_cc, exp_run, exp_done;
  logic [15:0] exp_disp;

  stopwatch_ctrl #(
    .NUMBER_OF_DIGITS(4),
    .NUMBER_OF_BITS_PER_DIGIT(4),
    .TICK_DIVIDER(TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_stop(start_stop),
    .lap(lap),
    .clear(clear),
    .mode_down(mode_down),
    .count(count),
    .count_enable(count_enable),
    .count_up_down(count_up_down),
    .count_clear(count_clear),
    .display_number(display_number),
    .running(running),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_eval();
    bit p_ss, p_lp, p_cl, tk, term;
    if (rst) begin
      mdl_idle = 1; mdl_run = 0; mdl_frozen = 0; mdl_finished = 0;
      mdl_up = 1; mdl_phase = 0; mdl_hold = 16'h0;
      prev_ss = 1; prev_lp = 1; prev_cl = 1;
      exp_ce = 0; exp_ud = 1; exp_cc = 1; exp_disp = 16'h0; exp_run = 0; exp_done = 0;
    end else begin
      p_ss = start_stop && !prev_ss;
      p_lp = lap && !prev_lp;
      p_cl = clear && !prev_cl;
      prev_ss = start_stop; prev_lp = lap; prev_cl = clear;

      tk   = mdl_run && (mdl_phase == TICKS - 1);
      term = tk && (mdl_up ? (count == 16'h9999) : (count == 16'h0000));
      exp_ce = tk && !term && !p_cl;
      exp_cc = p_cl;

      if (p_cl || mdl_idle || mdl_finished) mdl_phase = 0;
      else if (mdl_run) mdl_phase = (mdl_phase + 1) % TICKS;

      if (p_cl) begin
        mdl_idle = 1; mdl_run = 0; mdl_frozen = 0; mdl_finished = 0;
      end else if (term) begin
        mdl_finished = 1; mdl_run = 0; mdl_frozen = 0;
      end else if (p_ss) begin
        if (mdl_idle) begin
          mdl_idle = 0; mdl_run = 1; mdl_up = !mode_down;
        end else if (mdl_run) begin
          mdl_run = 0; mdl_frozen = 0;
        end else if (!mdl_finished) begin
          mdl_run = 1;
        end
      end else if (p_lp && mdl_run) begin
        mdl_frozen = !mdl_frozen;
        if (mdl_frozen) mdl_hold = count;
      end

      exp_disp = mdl_frozen ? mdl_hold : count;
      exp_run  = mdl_run;
      exp_done = mdl_finished;
      exp_ud   = mdl_up;
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check("count_enable",   {15'd0, count_enable},  {15'd0, exp_ce});
    check("count_up_down",  {15'd0, count_up_down}, {15'd0, exp_ud});
    check("count_clear",    {15'd0, count_clear},   {15'd0, exp_cc});
    check("display_number", display_number,         exp_disp);
    check("running",        {15'd0, running},       {15'd0, exp_run});
    check("done",           {15'd0, done},          {15'd0, exp_done});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input bit ss, input bit lp, input bit cl);
    start_stop = ss; lap = lp; clear = cl;
    step();
    start_stop = 0; lap = 0; clear = 0;
    step();
  endtask

  initial begin
    rst = 1; start_stop = 1; lap = 0; clear = 0; mode_down = 0; count = 16'h0000;
    run(3);

    // Reset release: count_clear visible for the first cycle only; held start is not a press.
    rst = 0;
    #1;
    check("count_clear_after_reset", {15'd0, count_clear}, 16'd1);
    run(3);
    check("held_start_no_run", {15'd0, running}, 16'd0);
    start_stop = 0;
    run(2);

    // First tick TICKS cycles after entering RUNNING, then periodic.
    press(1, 0, 0);
    run(12);

    // Pause mid-interval, wait, resume.
    count = 16'h0012;
    run(1);
    press(1, 0, 0);
    run(20);
    press(1, 0, 0);
    run(9);

    // Lap freezes the display while ticks continue.
    count = 16'h0037;
    press(0, 1, 0);
    count = 16'h0040;
    run(6);
    check("lap_hold", display_number, 16'h0037);
    press(0, 1, 0);
    run(2);
    check("lap_release", display_number, 16'h0040);

    // Simultaneous clear/start/lap while running: clear wins.
    press(1, 1, 1);
    run(3);
    check("idle_after_combo", {15'd0, running}, 16'd0);

    // Held start makes a single transition.
    start_stop = 1;
    run(100);
    start_stop = 0;
    run(2);
    check("held_start_one_run", {15'd0, running}, 16'd1);
    press(0, 0, 1);

    // Down mode reaching zero ends the run; start and lap are ignored in DONE.
    mode_down = 1; count = 16'h0000;
    press(1, 0, 0);
    mode_down = 0;
    run(6);
    check("down_done", {15'd0, done}, 16'd1);
    press(1, 0, 0);
    press(0, 1, 0);
    run(6);
    check("done_ignores_buttons", {15'd0, done}, 16'd1);
    press(0, 0, 1);

    // Up mode at all nines ends without wrapping.
    count = 16'h9999;
    press(1, 0, 0);
    run(6);
    check("up_done", {15'd0, done}, 16'd1);
    press(0, 0, 1);

    // Reset mid-count aborts without a tick.
    count = 16'h0100;
    press(1, 0, 0);
    run(1);
    rst = 1;
    run(2);
    rst = 0;
    run(3);

    // Randomized phase against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0)  start_stop = ~start_stop;
      if ($urandom_range(9) == 0)  lap = ~lap;
      if ($urandom_range(39) == 0) clear = ~clear;
      if ($urandom_range(7) == 0)  mode_down = ~mode_down;
      if ($urandom_range(15) == 0) begin
        case ($urandom_range(3))
          0: count = 16'h0000;
          1: count = 16'h9999;
          2: count = 16'h0012;
          default: count = {4'($urandom_range(9)), 4'($urandom_range(9)),
                            4'($urandom_range(9)), 4'($urandom_range(9))};
        endcase
      end
      rst = ($urandom_range(299) == 0);
      step();
    end
    rst = 0;
    run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
